countdown_ctrl: RTL
===================

# countdown_ctrl

Control stage paired with the lab 1 down counter (`counter_down`). It generates the counter's `ena` and synchronous `reset` (load) inputs and watches the counter's `result`. It prescales the clock into decrement ticks and runs a start/pause/stop/expire state machine. On expiry it raises a one-cycle done pulse and optionally restarts the count automatically.

## Interface
- `dw`, default 8: width of the counter value bus; must match the counter's `dw`.
- `WIDTH`, default 7: counter load value; the count starts from this value. Must match the counter's `WIDTH`.
- `PRESCALE`, default 4: clock cycles per decrement tick; legal range ≥1.

Ports (clock and reset first):
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  level, sampled each cycle; starts or restarts the count in IDLE or EXPIRED.
- `stop`  input  1  level; abort to IDLE from any non-IDLE state; highest priority.
- `pause`  input  1  level; while high in RUN or PAUSED, counting is frozen.
- `auto_reload`  input  1  level; when high, EXPIRED restarts without needing `start`.
- `cnt_in`  input  dw  counter `result`.
- `cnt_ena`  output  1  drives the counter `ena`; combinational from registered state.
- `cnt_reload`  output  1  drives the counter's active-high synchronous reset (load of `WIDTH`); combinational from state.
- `done_pulse`  output  1  registered; high for exactly one cycle on entry to EXPIRED.
- `expired`  output  1  high while state is EXPIRED.
- `exp_count`  output  8  registered count of expiries; wraps from 255 to 0.
- `state`  output  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, LOAD=1, RUN=2, PAUSED=3, EXPIRED=4.
- IDLE: `cnt_reload`=1. Goes to LOAD when `start`=1.
- LOAD: `cnt_reload`=1. Clears the prescaler to 0. Goes to RUN unconditionally, unless `stop`=1, which goes to IDLE.
- RUN, in priority order:
  - `stop` → IDLE.
  - else `cnt_in`==0 → EXPIRED.
  - else `pause` → PAUSED.
  - else stay in RUN.
- PAUSED: `stop` → IDLE; `pause`=0 → RUN. The prescaler holds its value and `cnt_ena`=0.
- EXPIRED: `stop` → IDLE; `start` or `auto_reload` → LOAD; otherwise hold.
- Prescaler `pre`:
  - Width is max(1, $clog2(PRESCALE)).
  - In RUN it increments each cycle and wraps from PRESCALE-1 to 0.
  - It holds in PAUSED and is cleared in IDLE and LOAD.
- `cnt_ena` = (state==RUN) && (pre==PRESCALE-1) && (`cnt_in`!=0) && !`stop`. It is never asserted outside RUN, so the counter cannot underflow past 0.
- `cnt_reload` = (state==IDLE) || (state==LOAD).
- `done_pulse` is set on the edge that enters EXPIRED and cleared on the next edge.
- `exp_count` increments by 1 on the same edge that enters EXPIRED.
- `start` is ignored in LOAD, RUN and PAUSED.
- `pause` is ignored in IDLE, LOAD and EXPIRED.

## Timing
- Reset (`reset_n`=0, asynchronous) forces:
  - state=IDLE, `pre`=0, `done_pulse`=0, `exp_count`=0.
  - Hence `cnt_reload`=1, `cnt_ena`=0 and `expired`=0 while reset is held.
- `start` sampled high at edge k:
  - LOAD during cycle k..k+1.
  - The counter loads `WIDTH` at edge k+1.
  - RUN is entered at edge k+1 (call it E0).
- Decrement timing: the first `cnt_ena` is high in the cycle after edge E0+PRESCALE-1, and the counter decrements at edge E0+PRESCALE.
- `cnt_in` reaches 0 at edge E0+`WIDTH`·PRESCALE. EXPIRED is entered, and `done_pulse` rises, at edge E0+`WIDTH`·PRESCALE+1. With defaults that is 29 cycles after E0.
- Paused cycles add exactly one cycle each to the expiry time.
- `WIDTH`=0: RUN sees `cnt_in`==0 in its first cycle; EXPIRED is entered at edge E0+1.
- `PRESCALE`=1: `cnt_ena` is high every RUN cycle while `cnt_in`≠0.
- Simultaneous events:
  - `stop` with expiry: IDLE, no `done_pulse`, no `exp_count` increment.
  - `pause` with expiry: EXPIRED.
- `auto_reload` held high: EXPIRED lasts one cycle, then LOAD, then RUN. The period is `WIDTH`·PRESCALE+3 cycles per expiry.
- Reset asserted mid-RUN: state goes to IDLE immediately and `cnt_reload` asserts. The counter reloads `WIDTH` at the next clock edge.

## Test plan
- Reset, then `start` pulsed 1 cycle with defaults → `cnt_ena` high once every 4 cycles; `cnt_in` steps 7..0; `done_pulse` high 1 cycle, 29 cycles after RUN entry; `exp_count`=1; `expired` stays high.
- `pause` held for 10 cycles mid-count → `cnt_ena`=0 and `cnt_in` frozen during the pause; expiry delayed by exactly 10 cycles; `pre` resumes from its held value.
- `auto_reload`=1 for 3 periods → `done_pulse` every 31 cycles; `exp_count`=3; `cnt_reload` high 1 cycle in each LOAD.
- `stop` asserted in the same cycle that `cnt_in`==0 → state IDLE; no `done_pulse`; `exp_count` unchanged; `cnt_reload`=1.
- `reset_n` dropped mid-RUN, between clock edges → state=0 and `cnt_reload`=1 immediately; `cnt_in`=7 after the next edge; `exp_count`=0.
- `WIDTH`=0, `PRESCALE`=1 build, then `start` → EXPIRED 1 cycle after RUN entry; `cnt_ena` never asserted.

Source files
------------

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - prescaled start/pause/stop/expire control stage for the down counter
module countdown_ctrl #(
    parameter int dw       = 8,
    parameter int WIDTH    = 7,
    parameter int PRESCALE = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          auto_reload,
    input  logic [dw-1:0] cnt_in,
    output logic          cnt_ena,
    output logic          cnt_reload,
    output logic          done_pulse,
    output logic          expired,
    output logic [7:0]    exp_count,
    output logic [2:0]    state
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        PAUSED  = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    state_t        st;
    logic [PW-1:0] pre;
    logic          cnt_zero;

    assign cnt_zero = (cnt_in == '0);

    // Gating on cnt_zero keeps the counter from being decremented below 0;
    // gating on stop avoids a decrement on the cycle we abort.
    assign cnt_ena    = (st == RUN) && (pre == PRE_MAX) && !cnt_zero && !stop;
    assign cnt_reload = (st == IDLE) || (st == LOAD);
    assign expired    = (st == EXPIRED);
    assign state      = st;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= IDLE;
            pre        <= '0;
            done_pulse <= 1'b0;
            exp_count  <= 8'd0;
        end else begin
            done_pulse <= 1'b0;
            case (st)
                IDLE: begin
                    pre <= '0;
                    if (start) st <= LOAD;
                end
                LOAD: begin
                    pre <= '0;
                    st  <= stop ? IDLE : RUN;
                end
                RUN: begin
                    pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
                    if (stop) begin
                        st <= IDLE;
                    end else if (cnt_zero) begin
                        st         <= EXPIRED;
                        done_pulse <= 1'b1;
                        exp_count  <= exp_count + 8'd1;
                    end else if (pause) begin
                        st <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (stop)        st <= IDLE;
                    else if (!pause) st <= RUN;
                end
                EXPIRED: begin
                    if (stop)                      st <= IDLE;
                    else if (start || auto_reload) st <= LOAD;
                end
                default: begin
                    st  <= IDLE;
                    pre <= '0;
                end
            endcase
        end
    end

endmodule
